// File: rtl/cursor_line_fetcher.sv
// Prefetches one 60-px cursor sprite row per scanline from the sprite ROM and overlays it with key masking and clipping.
// Latency: row fetch 61 cycles after line_start; pixel path exactly 1 cycle. Backpressure: none, fetch runs free-flowing.
module cursor_line_fetcher #(
  parameter int          SPRITE_W  = 60,
  parameter int          SPRITE_H  = 60,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        line_start,
  input  logic [9:0]  next_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        fetch_busy,
  output logic        cursor_on,
  output logic [23:0] cursor_rgb
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [9:0]  mx, my, line_y;
  logic        line_valid;
  logic [5:0]  cnt;
  logic [10:0] row, col;
  logic        row_hit, col_hit, pix_on;
  logic [15:0] row16, base_addr;
  logic [23:0] line_buf [SPRITE_W];
  logic [23:0] pix;
  logic        wr_en;
  logic [5:0]  wr_idx;

  // 11-bit differences so a negative offset shows up in bit 10 rather than wrapping
  assign row       = {1'b0, next_y} - {1'b0, my};
  assign row_hit   = !row[10] && (row[9:0] < 10'(SPRITE_H)) && (next_y < 10'(V_ACTIVE));
  assign row16     = {6'd0, row[9:0]};
  assign base_addr = (row16 << 6) - (row16 << 2);

  assign col       = {1'b0, DrawX} - {1'b0, mx};
  assign col_hit   = !col[10] && (col[9:0] < 10'(SPRITE_W)) && (DrawX < 10'(H_ACTIVE));
  assign pix       = line_buf[col[5:0]];
  assign pix_on    = line_valid && (DrawY == line_y) && col_hit && (pix != KEY_COLOR);

  assign fetch_busy = (state != IDLE);

  // ROM returns data one cycle after the address, so the write trails the counter by one
  assign wr_en  = ((state == FETCH) && (cnt != 6'd0)) || (state == DRAIN);
  assign wr_idx = (state == DRAIN) ? 6'(SPRITE_W - 1) : cnt - 6'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      FETCH:   if (cnt == 6'(SPRITE_W - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (line_start) state_nxt = row_hit ? FETCH : IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mx         <= '0;
      my         <= '0;
      line_y     <= '0;
      line_valid <= 1'b0;
      cnt        <= '0;
      rom_addr   <= '0;
      cursor_on  <= 1'b0;
      cursor_rgb <= '0;
    end else begin
      if (frame_start) begin
        mx <= mouse_x;
        my <= mouse_y;
      end
      if (line_start) begin
        line_y     <= next_y;
        line_valid <= 1'b0;
        if (row_hit) begin
          cnt      <= '0;
          rom_addr <= base_addr;
        end
      end else if (state == FETCH) begin
        if (cnt != 6'(SPRITE_W - 1)) begin
          cnt      <= cnt + 6'd1;
          rom_addr <= rom_addr + 16'd1;
        end
      end else if (state == DRAIN) begin
        line_valid <= 1'b1;
      end
      cursor_on  <= pix_on;
      cursor_rgb <= pix_on ? pix : 24'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && wr_en) line_buf[wr_idx] <= rom_data;
  end

endmodule

// File: tb/tb_cursor_line_fetcher.sv
// Directed bench for cursor_line_fetcher with a registered sprite-ROM model whose words encode their address.
module tb_cursor_line_fetcher;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [9:0]  mouse_x = '0;
  logic [9:0]  mouse_y = '0;
  logic        line_start = 1'b0;
  logic [9:0]  next_y = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [15:0] rom_addr;
  logic [23:0] rom_data = '0;
  logic        fetch_busy;
  logic        cursor_on;
  logic [23:0] cursor_rgb;

  int n_chk  = 0;
  int n_fail = 0;
  int key_addr = -1;
  int n;

  cursor_line_fetcher dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .line_start(line_start), .next_y(next_y), .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr(rom_addr), .rom_data(rom_data), .fetch_busy(fetch_busy),
    .cursor_on(cursor_on), .cursor_rgb(cursor_rgb)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_val(input int a);
    if (a == key_addr) return 24'hFF00FF;
    return {8'h3C, 16'(a)};
  endfunction

  always @(posedge Clk) rom_data <= rom_val(int'(rom_addr));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fetch(output int cycles);
    cycles = 0;
    while (fetch_busy && cycles < 100) begin
      cycles++;
      step();
    end
  endtask

  task automatic pixel(input string tag, input int x, input int y, input logic on_exp, input logic [23:0] rgb_exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    step();
    chk({tag, "_on"}, 32'(cursor_on), 32'(on_exp));
    chk({tag, "_rgb"}, 32'(cursor_rgb), 32'(rgb_exp));
  endtask

  task automatic start_line(input int y);
    line_start = 1'b1;
    next_y = 10'(y);
    step();
    line_start = 1'b0;
  endtask

  task automatic set_mouse(input int x, input int y);
    frame_start = 1'b1;
    mouse_x = 10'(x);
    mouse_y = 10'(y);
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  initial begin
    step();
    step();
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(fetch_busy), 32'd0);
    chk("rst_on", 32'(cursor_on), 32'd0);
    chk("rst_rgb", 32'(cursor_rgb), 32'd0);
    Reset = 1'b0;

    // Basic row fetch: mouse (100,50), scanline 52 -> row 2, base 120
    set_mouse(100, 50);
    start_line(52);
    for (int k = 0; k < 60; k++) begin
      chk("fetch_addr", 32'(rom_addr), 32'(120 + k));
      chk("fetch_busy", 32'(fetch_busy), 32'd1);
      step();
    end
    chk("drain_busy", 32'(fetch_busy), 32'd1);
    step();
    chk("done_busy", 32'(fetch_busy), 32'd0);
    chk("hold_addr", 32'(rom_addr), 32'd179);
    pixel("px105", 105, 52, 1'b1, {8'h3C, 16'd125});
    pixel("px99", 99, 52, 1'b0, 24'd0);
    pixel("px160", 160, 52, 1'b0, 24'd0);
    pixel("px159", 159, 52, 1'b1, {8'h3C, 16'd179});
    pixel("px100", 100, 52, 1'b1, {8'h3C, 16'd120});
    pixel("wrong_y", 105, 53, 1'b0, 24'd0);

    // Transparent pixel and no partial rows while refetching
    key_addr = 125;
    start_line(52);
    pixel("partial", 105, 52, 1'b0, 24'd0);
    wait_fetch(n);
    chk("refetch_len", 32'(n), 32'd60);
    pixel("key", 105, 52, 1'b0, 24'd0);
    pixel("after_key", 106, 52, 1'b1, {8'h3C, 16'd126});
    key_addr = -1;

    // Vertical misses and the last sprite row
    start_line(49);
    chk("miss49_busy", 32'(fetch_busy), 32'd0);
    chk("miss49_addr", 32'(rom_addr), 32'd179);
    pixel("miss49", 105, 49, 1'b0, 24'd0);
    start_line(110);
    chk("miss110_busy", 32'(fetch_busy), 32'd0);
    pixel("miss110", 105, 110, 1'b0, 24'd0);
    start_line(109);
    chk("row59_addr", 32'(rom_addr), 32'd3540);
    wait_fetch(n);
    chk("row59_len", 32'(n), 32'd61);
    pixel("row59_first", 100, 109, 1'b1, {8'h3C, 16'd3540});
    pixel("row59_last", 159, 109, 1'b1, {8'h3C, 16'd3599});

    // Rows at or beyond the last visible line are never fetched
    set_mouse(100, 470);
    start_line(480);
    chk("vclip_busy", 32'(fetch_busy), 32'd0);
    start_line(479);
    chk("v479_addr", 32'(rom_addr), 32'd540);
    wait_fetch(n);
    chk("v479_len", 32'(n), 32'd61);

    // Right-edge clipping, no wrap to the left edge
    set_mouse(620, 50);
    start_line(50);
    chk("clip_addr", 32'(rom_addr), 32'd0);
    wait_fetch(n);
    pixel("clip639", 639, 50, 1'b1, {8'h3C, 16'd19});
    pixel("clip620", 620, 50, 1'b1, {8'h3C, 16'd0});
    pixel("clip640", 640, 50, 1'b0, 24'd0);
    pixel("clip0", 0, 50, 1'b0, 24'd0);
    pixel("clip19", 19, 50, 1'b0, 24'd0);

    // frame_start coinciding with line_start uses the old position (my=50 -> row 1)
    frame_start = 1'b1;
    mouse_x = 10'd0;
    mouse_y = 10'd0;
    start_line(51);
    frame_start = 1'b0;
    chk("same_cyc_addr", 32'(rom_addr), 32'd60);

    // Abort: new line_start 30 cycles into the fetch (now my=0 -> row 10)
    repeat (29) step();
    chk("pre_abort_addr", 32'(rom_addr), 32'd89);
    start_line(10);
    chk("abort_addr", 32'(rom_addr), 32'd600);
    wait_fetch(n);
    chk("abort_len", 32'(n), 32'd61);
    pixel("abort_new", 5, 10, 1'b1, {8'h3C, 16'd605});
    pixel("abort_old", 5, 51, 1'b0, 24'd0);

    // Reset overrides line_start and clears line_valid
    DrawX = 10'd5;
    DrawY = 10'd10;
    Reset = 1'b1;
    line_start = 1'b1;
    next_y = 10'd10;
    step();
    line_start = 1'b0;
    Reset = 1'b0;
    chk("rst_ovr_busy", 32'(fetch_busy), 32'd0);
    chk("rst_ovr_addr", 32'(rom_addr), 32'd0);
    chk("rst_ovr_on", 32'(cursor_on), 32'd0);
    pixel("rst_valid", 5, 10, 1'b0, 24'd0);

    // Reset in the middle of a fetch
    start_line(12);
    chk("mid_addr", 32'(rom_addr), 32'd720);
    repeat (20) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("mid_rst_busy", 32'(fetch_busy), 32'd0);
    chk("mid_rst_addr", 32'(rom_addr), 32'd0);
    chk("mid_rst_on", 32'(cursor_on), 32'd0);
    repeat (3) step();
    chk("mid_rst_idle", 32'(fetch_busy), 32'd0);
    pixel("mid_rst_px", 5, 12, 1'b0, 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cursor_line_fetcher.md
Name: cursor_line_fetcher

Overview:
- Reader side of the 60x60x24-bit mouse-cursor sprite ROM (1-cycle registered read, 16-bit address, 24-bit data).
- At each horizontal-blank start, it prefetches the cursor row needed for the next scanline into a local 60-entry line buffer.
- During active video, it serves cursor pixels from that buffer with fixed 1-cycle latency, so the VGA colour mapper can overlay the cursor on the board.
- Handles transparency-key masking and screen-edge clipping.

Parameters:
- SPRITE_W, 60, sprite width in pixels.
- SPRITE_H, 60, sprite height in pixels.
- KEY_COLOR, 24'hFF00FF, transparent colour; pixels of this value are never drawn.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines per frame.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- frame_start  input  1  one-cycle pulse at vertical-blank start; latches mouse position.
- mouse_x  input  10  cursor hotspot (top-left) X, sampled on frame_start.
- mouse_y  input  10  cursor hotspot Y, sampled on frame_start.
- line_start  input  1  one-cycle pulse at horizontal-blank start.
- next_y  input  10  scanline that will be drawn after this blank; valid with line_start.
- DrawX  input  10  current pixel X.
- DrawY  input  10  current pixel Y.
- rom_addr  output  16  read address to sprite ROM.
- rom_data  input  24  ROM data; corresponds to rom_addr of previous cycle.
- fetch_busy  output  1  high while a row fetch is in progress.
- cursor_on  output  1  cursor pixel opaque at (DrawX,DrawY) of previous cycle.
- cursor_rgb  output  24  colour for that pixel; 0 when cursor_on=0.

Behaviour:
- Reset values:
  - State IDLE; rom_addr=0; fetch_busy=0; cursor_on=0; cursor_rgb=0.
  - Latched mx/my=0; line_valid=0; buffer contents don't-care.
  - Reset overrides every other input in the same cycle.
- Position latch: on frame_start, mx<=mouse_x and my<=mouse_y. New values first affect the next line_start.
- Row select:
  - On line_start, compute row = next_y - my (11-bit signed).
  - Hit iff 0 <= row <= SPRITE_H-1 and next_y < V_ACTIVE.
  - Miss: line_valid<=0, stay IDLE.
  - Hit: line_valid<=0, latch row, enter FETCH.
- FSM states:
  - IDLE: waiting for line_start.
  - FETCH:
    - Cycle k (k=0..SPRITE_W-1) drives rom_addr = row*SPRITE_W + k.
    - Implement row*60 as (row<<6)-(row<<2); the result is 16 bits.
    - fetch_busy=1 throughout.
  - DRAIN: one cycle capturing the last word. Buffer entry k is written from rom_data at cycle k+1.
  - Exit DRAIN: line_valid<=1, fetch_busy<=0, go to IDLE.
  - Total fetch is SPRITE_W+1 = 61 cycles after line_start.
- line_start during FETCH/DRAIN: abort the current fetch and restart from column 0 with the new row, or go to IDLE on a miss. line_valid stays 0.
- Pixel path (registered, latency exactly 1 cycle):
  - col = DrawX - mx (11-bit signed).
  - on = line_valid and DrawY == latched next_y and 0 <= col <= SPRITE_W-1 and DrawX < H_ACTIVE and buf[col] != KEY_COLOR.
  - Next cycle: cursor_on<=on; cursor_rgb<=on ? buf[col] : 0.
- Fetch not complete when the line's pixels arrive: line_valid=0, so cursor_on=0 for that line. Never output partial rows.
- Clipping: mx > H_ACTIVE-SPRITE_W draws only columns with DrawX < H_ACTIVE, with no wrap to X=0. Likewise rows at or beyond V_ACTIVE are never fetched.
- Same-cycle frame_start and line_start: the row compare uses the old mx/my.
- rom_addr holds its last value when not fetching.

Test Plan:
- Reset mid-FETCH (cycle 20) -> next cycle fetch_busy=0, rom_addr=0, cursor_on=0, line_valid=0; no further buffer writes.
- mouse=(100,50) on frame_start; line_start with next_y=52 -> rom_addr = 120,121,…,179 on consecutive cycles; fetch_busy high exactly 61 cycles. Then DrawY=52, DrawX=105 -> one cycle later cursor_on=1, cursor_rgb=ROM[125] (non-key).
- Same setup with ROM[125]=24'hFF00FF -> cursor_on=0, cursor_rgb=0. DrawX=99 and DrawX=160 -> cursor_on=0.
- next_y=49 and next_y=110 with my=50 -> no fetch (fetch_busy stays 0), cursor_on=0 for the entire line.
- mouse_x=620, next_y hits row 0 -> DrawX=639 gives cursor_rgb=ROM[19]. DrawX=0 on the next line never asserts cursor_on from columns 20–59.
- Second line_start 30 cycles into a fetch with a new next_y -> rom_addr restarts at new_row*60. Only the new row is marked valid after 61 further cycles.
